// File: rtl/uart_hex_tx_arbiter.sv
// Round-robin arbiter that feeds one uart_tx with words rendered as uppercase ASCII hex,
// MSB nibble first, optionally terminated by CR LF.
module uart_hex_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 32,
    parameter int APPEND_CRLF = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ*DATA_W-1:0] i_word,
    output logic [N_REQ-1:0]        o_ack,
    output logic                    o_busy,
    output logic                    o_tx_start,
    output logic [7:0]              o_tx_byte,
    input  logic                    i_tx_active,
    input  logic                    i_tx_done
);

    localparam int NDIG  = DATA_W / 4;
    localparam int NCH   = NDIG + 2 * APPEND_CRLF;
    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(NCH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   w_grant_idx;
    logic [PTR_W-1:0]   w_next_rr;
    logic [PTR_W:0]     w_scan;
    logic               w_grant_valid;
    logic [DATA_W-1:0]  r_shift;
    logic [CNT_W-1:0]   r_char_cnt;
    logic [N_REQ-1:0]   r_ack;
    logic               w_capture;
    logic               w_advance;
    logic               w_last_char;
    logic [3:0]         w_nibble;
    logic [7:0]         w_char;

    // Scan requesters starting at the round-robin pointer, wrapping modulo N_REQ.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        w_scan        = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_scan = {1'b0, r_rr_ptr} + (PTR_W + 1)'(i);
            if (w_scan >= (PTR_W + 1)'(N_REQ)) begin
                w_scan = w_scan - (PTR_W + 1)'(N_REQ);
            end
            if (!w_grant_valid && i_req[w_scan[PTR_W-1:0]]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = w_scan[PTR_W-1:0];
            end
        end
        if (w_grant_idx == PTR_W'(N_REQ - 1)) begin
            w_next_rr = '0;
        end else begin
            w_next_rr = w_grant_idx + PTR_W'(1);
        end
    end

    // The word is shifted left once per digit, so the current nibble is always the top one.
    always_comb begin
        w_nibble    = r_shift[DATA_W-1 -: 4];
        w_last_char = (r_char_cnt == CNT_W'(NCH - 1));
        if (r_char_cnt < CNT_W'(NDIG)) begin
            if (w_nibble < 4'd10) begin
                w_char = 8'h30 + {4'h0, w_nibble};
            end else begin
                w_char = 8'h37 + {4'h0, w_nibble};
            end
        end else if (r_char_cnt == CNT_W'(NDIG)) begin
            w_char = 8'h0D;
        end else begin
            w_char = 8'h0A;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_advance    = 1'b0;
        o_tx_start   = 1'b0;
        o_tx_byte    = 8'h00;
        o_busy       = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_grant_valid) begin
                    w_capture    = 1'b1;
                    w_next_state = S_SEND;
                end
            end
            S_SEND: begin
                if (!i_tx_active) begin
                    o_tx_start   = 1'b1;
                    o_tx_byte    = w_char;
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_tx_done) begin
                    if (w_last_char) begin
                        w_next_state = S_IDLE;
                    end else begin
                        w_advance    = 1'b1;
                        w_next_state = S_SEND;
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr_ptr   <= '0;
            r_shift    <= '0;
            r_char_cnt <= '0;
            r_ack      <= '0;
        end else begin
            r_ack <= w_capture ? (N_REQ'(1) << w_grant_idx) : '0;
            if (w_capture) begin
                r_shift    <= i_word[w_grant_idx * DATA_W +: DATA_W];
                r_char_cnt <= '0;
                r_rr_ptr   <= w_next_rr;
            end else if (w_advance) begin
                r_shift    <= r_shift << 4;
                r_char_cnt <= r_char_cnt + CNT_W'(1);
            end
        end
    end

    assign o_ack = r_ack;

endmodule

// File: tb/tb_uart_hex_tx_arbiter.sv
// Directed bench for uart_hex_tx_arbiter: a CRLF build and a digits-only build,
// each driven by a small uart_tx model that reports done 10 cycles after a start.
module tb_uart_hex_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic [3:0]  req = '0;
    logic [63:0] word = '0;
    logic [3:0]  ack;
    logic        busy, txStart;
    logic [7:0]  txByte;
    logic        mActive = 1'b0, mDone = 1'b0;
    int          mCnt = 0;
    logic        forceActive = 1'b0, spurDone = 1'b0;
    logic        txActive, txDone;
    logic [7:0]  byteQ[$];
    int          startCount = 0;
    int          ackCount = 0;

    logic [3:0]  bReq = '0;
    logic [63:0] bWord = '0;
    logic [3:0]  bAck;
    logic        bBusy, bStart;
    logic [7:0]  bByte;
    logic        bActive = 1'b0, bDone = 1'b0;
    int          bCnt = 0;
    logic [7:0]  bByteQ[$];

    int          passCount = 0;
    int          failCount = 0;
    int          checkCount = 0;

    assign txActive = mActive | forceActive;
    assign txDone   = mDone | spurDone;

    always #5 clk = ~clk;

    uart_hex_tx_arbiter #(.N_REQ(4), .DATA_W(16), .APPEND_CRLF(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_word(word),
        .o_ack(ack), .o_busy(busy), .o_tx_start(txStart), .o_tx_byte(txByte),
        .i_tx_active(txActive), .i_tx_done(txDone)
    );

    uart_hex_tx_arbiter #(.N_REQ(4), .DATA_W(16), .APPEND_CRLF(0)) dutNoCrlf (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(bReq), .i_word(bWord),
        .o_ack(bAck), .o_busy(bBusy), .o_tx_start(bStart), .o_tx_byte(bByte),
        .i_tx_active(bActive), .i_tx_done(bDone)
    );

    // uart_tx stand-in: logs each started char, goes active after the start is registered,
    // and pulses done for one cycle ten cycles later.
    always @(negedge clk) begin
        if (!rst_n) begin
            mCnt = 0; mActive = 1'b0; mDone = 1'b0;
        end else begin
            mDone = 1'b0;
            if (ack != 4'b0000) ackCount++;
            if (txStart) begin
                byteQ.push_back(txByte);
                startCount++;
                mCnt = 10;
            end else if (mCnt > 0) begin
                mCnt--;
                if (mCnt == 0) begin
                    mDone = 1'b1; mActive = 1'b0;
                end else begin
                    mActive = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            bCnt = 0; bActive = 1'b0; bDone = 1'b0;
        end else begin
            bDone = 1'b0;
            if (bStart) begin
                bByteQ.push_back(bByte);
                bCnt = 10;
            end else if (bCnt > 0) begin
                bCnt--;
                if (bCnt == 0) begin
                    bDone = 1'b1; bActive = 1'b0;
                end else begin
                    bActive = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [63:0] w);
        req  = r;
        word = w;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        req = '0; bReq = '0; forceActive = 1'b0; spurDone = 1'b0;
        repeat (3) @(negedge clk);
        byteQ.delete();
        bByteQ.delete();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic waitAck(input bit sel, input int budget, output logic [3:0] a);
        a = '0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((sel ? bAck : ack) != 4'b0000) begin
                a = sel ? bAck : ack;
                break;
            end
        end
    endtask

    task automatic waitIdle(input bit sel, input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!(sel ? bBusy : busy)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // exp holds the n expected chars packed with the first char in the most significant byte.
    task automatic checkFrame(input string tag, input bit sel, input int n, input logic [95:0] exp);
        int         sz;
        logic [7:0] got;
        sz = sel ? bByteQ.size() : byteQ.size();
        checkOutput($sformatf("%s_count", tag), sz, n);
        for (int i = 0; i < n; i++) begin
            got = 8'h00;
            if (i < sz) got = sel ? bByteQ[i] : byteQ[i];
            checkOutput($sformatf("%s_byte%0d", tag, i), {24'h0, got}, {24'h0, exp[8*(n-1-i) +: 8]});
        end
    endtask

    initial begin
        logic [3:0] a;
        logic       ok;
        int         idleCycles;
        int         sc;
        logic [3:0] expOrder[8];

        #1;
        doReset();
        checkOutput("rst_ack", {28'h0, ack}, 0);
        checkOutput("rst_busy", {31'h0, busy}, 0);
        checkOutput("rst_start", {31'h0, txStart}, 0);
        checkOutput("rst_byte", {24'h0, txByte}, 0);

        $display("[TB] single word 0x1A2F from requester 0");
        applyStimulus(4'b0001, 64'h0000_0000_0000_1A2F);
        waitAck(1'b0, 20, a);
        checkOutput("t1_ack", {28'h0, a}, 32'h1);
        checkOutput("t1_busy_with_ack", {31'h0, busy}, 1);
        checkOutput("t1_first_start", {31'h0, txStart}, 1);
        checkOutput("t1_first_byte", {24'h0, txByte}, 32'h31);
        req = 4'b0000;
        waitIdle(1'b0, 200, ok);
        checkOutput("t1_idle", {31'h0, ok}, 1);
        checkFrame("t1", 1'b0, 6, 96'h31_41_32_46_0D_0A);

        $display("[TB] round robin with all requests held");
        doReset();
        applyStimulus(4'b1111, 64'h4444_3333_2222_1111);
        expOrder = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b1000, 4'b0010};
        for (int i = 0; i < 8; i++) begin
            waitAck(1'b0, 200, a);
            checkOutput($sformatf("t2_ack%0d", i), {28'h0, a}, {28'h0, expOrder[i]});
            if (i == 4) req = 4'b1010;
        end
        req = 4'b0000;
        waitIdle(1'b0, 200, ok);
        checkOutput("t2_idle", {31'h0, ok}, 1);

        $display("[TB] back-to-back frames 0x0000 then 0xFFFF");
        doReset();
        applyStimulus(4'b0001, 64'h0000_0000_0000_0000);
        waitAck(1'b0, 20, a);
        checkOutput("t3_ack1", {28'h0, a}, 32'h1);
        word = 64'h0000_0000_0000_FFFF;
        waitIdle(1'b0, 200, ok);
        checkOutput("t3_idle1", {31'h0, ok}, 1);
        idleCycles = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack != 4'b0000) break;
            idleCycles++;
        end
        checkOutput("t3_ack2", {28'h0, ack}, 32'h1);
        checkOutput("t3_gap", idleCycles, 1);
        req = 4'b0000;
        waitIdle(1'b0, 200, ok);
        checkFrame("t3", 1'b0, 12, 96'h30_30_30_30_0D_0A_46_46_46_46_0D_0A);

        $display("[TB] reset in mid frame");
        doReset();
        applyStimulus(4'b0100, 64'h0000_1234_0000_0000);
        waitAck(1'b0, 20, a);
        checkOutput("t4_ack_pre", {28'h0, a}, 32'h4);
        req = 4'b0000;
        @(negedge clk);
        req = 4'b1100;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (byteQ.size() >= 3) break;
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t4_rst_ack", {28'h0, ack}, 0);
        checkOutput("t4_rst_busy", {31'h0, busy}, 0);
        checkOutput("t4_rst_start", {31'h0, txStart}, 0);
        checkOutput("t4_rst_byte", {24'h0, txByte}, 0);
        repeat (3) @(negedge clk);
        checkFrame("t4", 1'b0, 3, 96'h31_32_33);
        rst_n = 1'b1;
        waitAck(1'b0, 20, a);
        checkOutput("t4_ack_post", {28'h0, a}, 32'h4);
        req = 4'b0000;
        @(negedge clk);
        sc = ackCount;
        waitIdle(1'b0, 200, ok);
        repeat (20) @(negedge clk);
        checkOutput("t4_no_grant_dropped", ackCount, sc);

        $display("[TB] uart busy stalls the start");
        doReset();
        forceActive = 1'b1;
        applyStimulus(4'b0001, 64'h0000_0000_0000_ABCD);
        waitAck(1'b0, 20, a);
        checkOutput("t5_ack", {28'h0, a}, 32'h1);
        checkOutput("t5_start_held", {31'h0, txStart}, 0);
        req = 4'b0000;
        sc = startCount;
        repeat (20) @(negedge clk);
        checkOutput("t5_no_start", startCount, sc);
        checkOutput("t5_busy_held", {31'h0, busy}, 1);
        @(posedge clk);
        #1 forceActive = 1'b0;
        #1;
        checkOutput("t5_start_fires", {31'h0, txStart}, 1);
        checkOutput("t5_start_byte", {24'h0, txByte}, 32'h41);
        @(posedge clk);
        #1;
        checkOutput("t5_start_once", {31'h0, txStart}, 0);
        waitIdle(1'b0, 200, ok);
        checkFrame("t5", 1'b0, 6, 96'h41_42_43_44_0D_0A);
        sc = startCount;
        @(negedge clk);
        spurDone = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t5_spur_busy", {31'h0, busy}, 0);
        @(negedge clk);
        spurDone = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("t5_spur_no_start", startCount, sc);
        checkOutput("t5_spur_idle", {31'h0, busy}, 0);

        $display("[TB] digits-only build, word 0xBEEF");
        doReset();
        bWord = 64'h0000_0000_0000_BEEF;
        bReq  = 4'b0001;
        waitAck(1'b1, 20, a);
        checkOutput("t6_ack", {28'h0, a}, 32'h1);
        bReq = 4'b0000;
        waitIdle(1'b1, 200, ok);
        checkOutput("t6_idle", {31'h0, ok}, 1);
        checkFrame("t6", 1'b1, 4, 96'h42_45_45_46);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
